// File: rtl/n64_vinfo_ext_if.sv
`default_nettype none
//==============================================================================
// Module   : n64_vinfo_ext_if
// Brief    : N64 video-bus sync inputs and video-timing info outputs.
// Revision : 1.0 - initial release
//==============================================================================
interface n64_vinfo_ext_if;
    logic       nDSYNC;
    logic [3:0] S_i;
    logic       nForceDeBlur_i;
    logic       nDeBlurMan_i;
    logic [1:0] data_cnt;
    logic       n64_480i;
    logic       vmode;
    logic       vsync_neg;
    logic       vinfo_valid;
    logic [5:0] deblurparams_o;

    // master: the video-bus side; slave: the timing extractor
    modport master (
        output nDSYNC, S_i, nForceDeBlur_i, nDeBlurMan_i,
        input  data_cnt, n64_480i, vmode, vsync_neg, vinfo_valid, deblurparams_o
    );

    modport slave (
        input  nDSYNC, S_i, nForceDeBlur_i, nDeBlurMan_i,
        output data_cnt, n64_480i, vmode, vsync_neg, vinfo_valid, deblurparams_o
    );
endinterface
`default_nettype wire

// File: rtl/n64_vinfo_ext.sv
`default_nettype none
//==============================================================================
// Module   : n64_vinfo_ext
// Brief    : Word-phase counter, 480i / PAL detection and de-blur parameter bus.
// Revision : 1.0 - initial release
//==============================================================================
module n64_vinfo_ext #(
    parameter int                LCNT_W  = 10,
    parameter logic [LCNT_W-1:0] LINE_TH = 10'd288
) (
    input wire              VCLK,
    input wire              nRST,
    n64_vinfo_ext_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_ONE_FIELD = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    localparam logic [LCNT_W-1:0] c_line_max = '1;
    localparam logic [LCNT_W-1:0] c_line_one = LCNT_W'(1);

    logic [1:0]        r_data_cnt;
    logic [3:0]        r_s_pre;
    logic [LCNT_W-1:0] r_line_cnt;
    logic              r_field_prev;
    logic              r_pending;
    logic              r_n64_480i;
    logic              r_vmode;
    logic              r_vsync_neg;
    logic              r_nforce_deblur;
    logic              r_ndeblur_man;
    state_t            r_state;
    state_t            w_state_eff;
    state_t            w_state_next;

    logic w_vneg;
    logic w_hpos;
    logic w_line_sat;
    logic w_est_en;
    logic w_field;
    logic w_il_est;
    logic w_unused_sync;

    // Edges exist only on sync words, compared against the previous sync word.
    assign w_vneg     = !bus.nDSYNC &&  r_s_pre[3] && !bus.S_i[3];
    assign w_hpos     = !bus.nDSYNC && !r_s_pre[1] &&  bus.S_i[1];
    assign w_line_sat = (r_line_cnt == c_line_max);
    assign w_field    = bus.S_i[1];
    assign w_il_est   = (w_field != r_field_prev);

    // A saturated line counter means vsync was lost: behave as if in INIT,
    // so a vneg arriving in that same cycle is treated as a first field.
    assign w_state_eff = w_line_sat ? ST_INIT : r_state;

    assign w_unused_sync = ^{r_s_pre[2], r_s_pre[0]};

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_eff;
        w_est_en     = 1'b0;
        if (w_vneg) begin
            unique case (w_state_eff)
                ST_INIT: begin
                    w_state_next = ST_ONE_FIELD;
                end
                ST_ONE_FIELD: begin
                    w_state_next = ST_LOCKED;
                    w_est_en     = 1'b1;
                end
                ST_LOCKED: begin
                    w_state_next = ST_LOCKED;
                    w_est_en     = 1'b1;
                end
                default: begin
                    w_state_next = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            r_data_cnt      <= 2'd0;
            r_s_pre         <= 4'hF;
            r_line_cnt      <= '0;
            r_field_prev    <= 1'b0;
            r_pending       <= 1'b0;
            r_n64_480i      <= 1'b0;
            r_vmode         <= 1'b0;
            r_vsync_neg     <= 1'b0;
            r_nforce_deblur <= 1'b1;
            r_ndeblur_man   <= 1'b1;
        end else begin
            r_data_cnt  <= bus.nDSYNC ? (r_data_cnt + 2'd1) : 2'd1;
            r_vsync_neg <= w_vneg;

            if (!bus.nDSYNC) begin
                r_s_pre <= bus.S_i;
            end

            if (w_vneg) begin
                r_line_cnt      <= '0;
                r_field_prev    <= w_field;
                r_nforce_deblur <= bus.nForceDeBlur_i;
                r_ndeblur_man   <= bus.nDeBlurMan_i;
            end else if (w_hpos && !w_line_sat) begin
                r_line_cnt <= r_line_cnt + c_line_one;
            end

            // Interlace flag needs two agreeing, differing estimates in a row.
            if (w_est_en) begin
                r_vmode <= (r_line_cnt >= LINE_TH);
                if (w_il_est == r_n64_480i) begin
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_n64_480i <= w_il_est;
                    r_pending  <= 1'b0;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign bus.data_cnt       = r_data_cnt;
    assign bus.n64_480i       = r_n64_480i;
    assign bus.vmode          = r_vmode;
    assign bus.vsync_neg      = r_vsync_neg;
    assign bus.vinfo_valid    = (r_state == ST_LOCKED);
    assign bus.deblurparams_o = {r_data_cnt, r_n64_480i, r_vmode,
                                 r_nforce_deblur, r_ndeblur_man};

endmodule
`default_nettype wire

// File: tb/tb_n64_vinfo_ext.sv
`default_nettype none
//==============================================================================
// Module   : tb_n64_vinfo_ext
// Brief    : Vector table, directed field sequences and random fields vs. model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_n64_vinfo_ext;

    localparam int LCNT_W   = 10;
    localparam int LINE_TH  = 288;
    localparam int LINE_MAX = (1 << LCNT_W) - 1;

    logic VCLK = 1'b0;
    logic nRST = 1'b0;
    n64_vinfo_ext_if bus ();

    n64_vinfo_ext #(.LCNT_W(LCNT_W), .LINE_TH(10'd288)) dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 VCLK = ~VCLK;

    int   n_checks = 0;
    int   n_errors = 0;
    logic rst_drv   = 1'b0;
    logic cfg_force = 1'b1;
    logic cfg_man   = 1'b1;

    // Reference model: field-level bookkeeping of the video timing rules.
    bit         m_armed = 0;
    int         m_dc, m_lines, m_fields, m_run;
    logic [3:0] m_spre;
    logic       m_fprev, m_480i, m_vmode, m_vsn, m_cf, m_cm;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_update(input logic nd, input logic [3:0] s, input logic rstn,
                                input logic fi, input logic mi);
        logic vneg, hpos, il;
        if (!rstn) begin
            m_dc = 0; m_lines = 0; m_fields = 0; m_run = 0; m_spre = 4'hF;
            m_fprev = 0; m_480i = 0; m_vmode = 0; m_vsn = 0; m_cf = 1; m_cm = 1;
            m_armed = 1;
            return;
        end
        if (m_lines == LINE_MAX) m_fields = 0;
        vneg = !nd && m_spre[3] && !s[3];
        hpos = !nd && !m_spre[1] && s[1];
        if (!nd) m_spre = s;
        m_dc  = nd ? (m_dc + 1) % 4 : 1;
        m_vsn = vneg;
        if (vneg) begin
            if (m_fields >= 1) begin
                il      = (s[1] != m_fprev);
                m_vmode = (m_lines >= LINE_TH);
                if (il != m_480i) begin
                    m_run++;
                    if (m_run == 2) begin
                        m_480i = il;
                        m_run  = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_fprev  = s[1];
            m_lines  = 0;
            m_cf     = fi;
            m_cm     = mi;
            m_fields = (m_fields >= 2) ? 2 : m_fields + 1;
        end else if (hpos && m_lines < LINE_MAX) begin
            m_lines++;
        end
    endtask

    function automatic logic [11:0] got_vec();
        return {bus.data_cnt, bus.n64_480i, bus.vmode, bus.vsync_neg,
                bus.vinfo_valid, bus.deblurparams_o};
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [1:0] dc;
        dc = 2'(m_dc);
        return {dc, m_480i, m_vmode, m_vsn, (m_fields == 2), dc, m_480i, m_vmode, m_cf, m_cm};
    endfunction

    // One VCLK cycle: compare against the model, then drive the next inputs.
    task automatic step(input logic nd, input logic [3:0] s);
        @(negedge VCLK);
        if (m_armed) chk("model", 32'(got_vec()), 32'(exp_vec()));
        nRST               = rst_drv;
        bus.nDSYNC         = nd;
        bus.S_i            = s;
        bus.nForceDeBlur_i = cfg_force;
        bus.nDeBlurMan_i   = cfg_man;
        model_update(nd, s, rst_drv, cfg_force, cfg_man);
    endtask

    task automatic settle();
        @(posedge VCLK);
        #1;
    endtask

    function automatic logic [3:0] sn(input logic nv, input logic nh);
        return {nv, 1'b1, nh, nv & nh};
    endfunction

    task automatic word(input logic [3:0] s, input int glen);
        step(1'b0, s);
        for (int i = 1; i < glen; i++) step(1'b1, 4'($urandom));
    endtask

    task automatic send_lines(input int n, input int glen, input int vlow);
        for (int i = 0; i < n; i++) begin
            word(sn(i >= vlow, 1'b0), glen);
            word(sn(i >= vlow, 1'b1), glen);
        end
    endtask

    task automatic vs_edge(input logic fbit);
        step(1'b0, sn(1'b0, fbit));
        settle();
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        rst_drv = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data_cnt"},  32'(bus.data_cnt),       32'd0);
        chk({tag, "_n64_480i"},  32'(bus.n64_480i),       32'd0);
        chk({tag, "_vmode"},     32'(bus.vmode),          32'd0);
        chk({tag, "_vsync_neg"}, 32'(bus.vsync_neg),      32'd0);
        chk({tag, "_valid"},     32'(bus.vinfo_valid),    32'd0);
        chk({tag, "_deblur"},    32'(bus.deblurparams_o), 32'h03);
    endtask

    typedef struct {
        logic       nd;
        logic [3:0] s;
        logic [1:0] dc;
        logic       vsn;
        logic       vld;
    } vec_t;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{1'b0, 4'hF, 2'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'hF, 2'd2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'hF, 2'd3, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 4'hF, 2'd1, 1'b0, 1'b0};  // missing sync wraps on
        tbl[5] = '{1'b0, 4'h7, 2'd1, 1'b1, 1'b0};  // first vneg
        tbl[6] = '{1'b0, 4'h7, 2'd1, 1'b0, 1'b0};  // back-to-back, vsync still low
        tbl[7] = '{1'b1, 4'hF, 2'd2, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 4'hF, 2'd1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 4'h5, 2'd1, 1'b1, 1'b1};  // second vneg locks

        bus.nDSYNC = 1'b1; bus.S_i = 4'hF;
        bus.nForceDeBlur_i = 1'b1; bus.nDeBlurMan_i = 1'b1;

        do_reset();
        settle();
        chk_reset_state("reset");

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].nd, tbl[i].s);
            settle();
            chk($sformatf("tbl%0d_data_cnt", i), 32'(bus.data_cnt),    32'(tbl[i].dc));
            chk($sformatf("tbl%0d_vsync_neg", i), 32'(bus.vsync_neg),  32'(tbl[i].vsn));
            chk($sformatf("tbl%0d_valid", i),    32'(bus.vinfo_valid), 32'(tbl[i].vld));
        end

        // Phase counter, one sync word in four.
        do_reset();
        for (int g = 0; g < 20; g++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0) step(1'b0, 4'hF);
                else        step(1'b1, 4'($urandom));
                settle();
                chk("phase_data_cnt", 32'(bus.data_cnt), 32'((k + 1) % 4));
                chk("phase_vsync_neg", 32'(bus.vsync_neg), 32'd0);
            end
        end

        // NTSC progressive: 263-line fields, nHSYNC high at every vsync edge.
        do_reset();
        vs_edge(1'b1);
        chk("ntsc_v1_vsync_neg", 32'(bus.vsync_neg), 32'd1);
        chk("ntsc_v1_valid", 32'(bus.vinfo_valid), 32'd0);
        send_lines(263, 4, 3);
        vs_edge(1'b1);
        chk("ntsc_v2_valid", 32'(bus.vinfo_valid), 32'd1);
        chk("ntsc_v2_vmode", 32'(bus.vmode), 32'd0);
        chk("ntsc_v2_480i", 32'(bus.n64_480i), 32'd0);
        chk("ntsc_v2_deblur32", 32'(bus.deblurparams_o[3:2]), 32'd0);
        send_lines(263, 4, 3);
        vs_edge(1'b1);
        chk("ntsc_v3_valid", 32'(bus.vinfo_valid), 32'd1);
        chk("ntsc_v3_480i", 32'(bus.n64_480i), 32'd0);
        send_lines(263, 4, 3);

        // PAL interlaced: 312/313 lines, alternating field bit.
        do_reset();
        vs_edge(1'b1);
        send_lines(312, 2, 3);
        vs_edge(1'b0);
        chk("pal_v2_vmode", 32'(bus.vmode), 32'd1);
        chk("pal_v2_valid", 32'(bus.vinfo_valid), 32'd1);
        chk("pal_v2_480i", 32'(bus.n64_480i), 32'd0);
        send_lines(313, 2, 3);
        chk("pal_pre_v3_480i", 32'(bus.n64_480i), 32'd0);
        vs_edge(1'b1);
        chk("pal_v3_480i", 32'(bus.n64_480i), 32'd1);
        chk("pal_v3_deblur3", 32'(bus.deblurparams_o[3]), 32'd1);

        // Hysteresis: repeat, alternate, repeat, alternate.
        send_lines(312, 2, 3); vs_edge(1'b1);
        chk("hyst_repeat1", 32'(bus.n64_480i), 32'd1);
        send_lines(313, 2, 3); vs_edge(1'b0);
        chk("hyst_alt1", 32'(bus.n64_480i), 32'd1);
        send_lines(312, 2, 3); vs_edge(1'b0);
        chk("hyst_repeat2", 32'(bus.n64_480i), 32'd1);
        send_lines(313, 2, 3); vs_edge(1'b1);
        chk("hyst_alt2", 32'(bus.n64_480i), 32'd1);

        // Overrides latch only on the next vneg.
        send_lines(150, 2, 3);
        cfg_force = 1'b0;
        cfg_man   = 1'b0;
        send_lines(162, 2, 0);
        chk("ovr_pre_force", 32'(bus.deblurparams_o[1]), 32'd1);
        chk("ovr_pre_man", 32'(bus.deblurparams_o[0]), 32'd1);
        vs_edge(1'b0);
        chk("ovr_post_force", 32'(bus.deblurparams_o[1]), 32'd0);
        chk("ovr_post_man", 32'(bus.deblurparams_o[0]), 32'd0);

        // Vsync lost: counter reaches all-ones after 1023 lines.
        send_lines(1022, 1, 3);
        settle();
        chk("nosync_1022_valid", 32'(bus.vinfo_valid), 32'd1);
        send_lines(1, 1, 0);
        step(1'b1, 4'hF);
        settle();
        chk("nosync_1023_valid", 32'(bus.vinfo_valid), 32'd0);
        chk("nosync_vmode_hold", 32'(bus.vmode), 32'd1);

        // Relock, then reset mid-frame.
        vs_edge(1'b0);
        chk("relock_v1_valid", 32'(bus.vinfo_valid), 32'd0);
        send_lines(312, 2, 3);
        vs_edge(1'b1);
        chk("relock_v2_valid", 32'(bus.vinfo_valid), 32'd1);
        send_lines(150, 2, 3);
        rst_drv = 1'b0;
        step(1'b1, 4'hF);
        rst_drv = 1'b1;
        settle();
        chk_reset_state("midrst");
        send_lines(100, 2, 0);
        vs_edge(1'b0);
        chk("midrst_v1_valid", 32'(bus.vinfo_valid), 32'd0);
        send_lines(312, 2, 3);
        vs_edge(1'b1);
        chk("midrst_v2_valid", 32'(bus.vinfo_valid), 32'd1);

        // Random fields: line counts straddling the threshold, random group
        // lengths (5 means a missing sync word), random field bits and overrides.
        for (int f = 0; f < 10; f++) begin
            int lines, glen, half;
            lines = $urandom_range(330, 250);
            glen  = $urandom_range(5, 1);
            half  = $urandom_range(lines - 10, 5);
            vs_edge(1'($urandom));
            send_lines(half, glen, 3);
            cfg_force = 1'($urandom);
            cfg_man   = 1'($urandom);
            send_lines(lines - half, glen, 0);
        end
        step(1'b1, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n64_vinfo_ext.md
# n64_vinfo_ext

Extracts video-timing information from the N64 multiplexed video bus and sequences the downstream per-pixel datapath (de-blur estimator, scaler). Runs in the VCLK domain directly after input registering. Generates the R/G/B word phase counter `data_cnt`, detects 480i vs. 240p and PAL vs. NTSC per field, and assembles the 6-bit de-blur parameter bus. User overrides are applied only on frame boundaries.

## Interface
- `LINE_TH`, default 10'd288: lines-per-field threshold; a field with at least this many lines is PAL.
- `LCNT_W`, default 10: line counter width; the counter saturates at all-ones.
- `VCLK` in 1: pixel-bus clock, about 50 MHz.
- `nRST` in 1: reset, synchronous, active-low; clock VCLK.
- `nDSYNC` in 1: low marks the sync word of each 4-word group.
- `S_i` in 4: sync nibble, valid when `nDSYNC` is low. Bits: [3] nVSYNC, [2] nCLAMP, [1] nHSYNC, [0] nCSYNC.
- `nForceDeBlur_i` in 1: 0 selects manual de-blur.
- `nDeBlurMan_i` in 1: manual de-blur setting.
- `data_cnt` out 2: word phase. 0 = sync, 1 = R, 2 = G, 3 = B.
- `n64_480i` out 1: 1 means interlaced output is detected.
- `vmode` out 1: 1 means PAL, 0 means NTSC.
- `vsync_neg` out 1: one-cycle pulse on a detected nVSYNC falling edge.
- `vinfo_valid` out 1: 1 once the mode outputs are trustworthy.
- `deblurparams_o` out 6: `{data_cnt, n64_480i, vmode, nForceDeBlur_r, nDeBlurMan_r}`.

## Operation
- **Phase counter.** Each cycle, if `nDSYNC` = 0 then `data_cnt` <= 1. Otherwise `data_cnt` <= `data_cnt` + 1, mod 4.
  - A missing sync wraps 3 → 0 → 1… and no error is raised.
- **Sync history.** `S_pre` (4 bits, reset 4'hF) is loaded with `S_i` on every cycle with `nDSYNC` = 0 and holds otherwise. Edge events are evaluated only in cycles with `nDSYNC` = 0:
  - vneg = `S_pre[3]` & !`S_i[3]`
  - hpos = !`S_pre[1]` & `S_i[1]`
- **Line counter.** `line_cnt` (LCNT_W bits) increments on hpos and saturates at all-ones. On vneg, `line_cnt` is cleared to 0. If vneg and hpos occur in the same cycle, `line_cnt` <= 0 (the clear wins).
- **Field/interlace estimator.** On vneg, capture `field` = `S_i[1]` (nHSYNC level at the vsync edge).
  - `il_est` = (`field` != `field_prev`); then `field_prev` <= `field`.
  - `n64_480i` changes only after two consecutive vnegs give the same `il_est` that differs from the current `n64_480i`. This uses a 1-bit pending flag, which is cleared when `il_est` equals `n64_480i`.
- **PAL/NTSC.** On vneg, `vmode` <= (`line_cnt` >= LINE_TH). The value compared is the pre-clear count of the field just ended.
- **Valid FSM.** States and transitions:
  - INIT → (vneg) → ONE_FIELD → (vneg) → LOCKED.
  - In LOCKED, `vinfo_valid` = 1.
  - From any state, `line_cnt` saturating at all-ones sends the FSM to INIT: no vsync was seen.
  - The first vneg in INIT updates `field_prev` and `line_cnt` only. `vmode` and `n64_480i` hold.
- **Config latch.** On vneg, `nForceDeBlur_r` <= `nForceDeBlur_i` and `nDeBlurMan_r` <= `nDeBlurMan_i`. Between vnegs they hold.
- `vsync_neg` is the registered vneg.

## Timing
- **Reset values** (`nRST` sampled low at a VCLK edge, taking priority over all other updates):
  - `data_cnt` 0, `n64_480i` 0, `vmode` 0, `vsync_neg` 0, `vinfo_valid` 0.
  - `nForceDeBlur_r` 1, `nDeBlurMan_r` 1.
  - `line_cnt` 0, `field_prev` 0, pending 0, FSM INIT, `S_pre` 4'hF.
- **Reset mid-frame.** The estimator restarts. Two further vnegs are needed before `vinfo_valid` = 1.
- **Latency.**
  - `data_cnt` = 1 in the cycle after `nDSYNC` is sampled low.
  - `vsync_neg`, `vmode`, the `n64_480i` update, the config latches and FSM steps all become visible in the cycle after the sync word carrying the edge.
- **Combinational output.** `deblurparams_o` is a combinational concatenation of registered signals. It has no added latency.
- **Back-to-back sync words** (`nDSYNC` low on consecutive cycles) are legal. `data_cnt` stays 1, and each word is edge-evaluated against the previous one.

## Test plan
1. **Phase counter.** Drive nDSYNC low 1 cycle in every 4, for 20 groups. Required: `data_cnt` sequence 1,2,3,0 repeating, `vsync_neg` never 1.
2. **NTSC progressive.** Send 3 fields of 263 lines each, with nHSYNC = 1 at every vsync edge. Required:
   - after the 2nd vneg, `vinfo_valid` = 1, `vmode` = 0, `n64_480i` = 0;
   - `deblurparams_o[3:2]` = 2'b00.
3. **PAL interlaced.** Send 312/313-line fields with nHSYNC alternating 0/1 at the vsync edges. Required:
   - `vmode` = 1 after the 2nd vneg;
   - `n64_480i` = 1 one cycle after the 3rd vneg, not before.
4. **Hysteresis.** Once locked at 480i, send a single field with a repeated field bit, then alternate again. Required: `n64_480i` stays 1 throughout.
5. **Overrides and no-sync.**
   - Toggle `nForceDeBlur_i` = 0 mid-field. Required: `deblurparams_o[1]` changes only one cycle after the next vneg.
   - Then stop vsync for 1023 lines. Required: `vinfo_valid` drops to 0.
6. **Mid-frame reset.** Assert nRST for 1 cycle mid-frame while locked. Required:
   - all outputs return to their reset values on the next cycle;
   - `vinfo_valid` = 1 again only after 2 further vnegs.
